wb_arbiter: RTL

Writeback arbiter feeding the single write port of `register_file`. It merges in-order pipeline results with out-of-order results from long-latency units (load/mul/div) and buffers the long-latency results in a small FIFO. It keeps a busy scoreboard of destination registers for hazard detection and, optionally, forwards in-flight write data to the read stage. It sits between the execute/memory stages and `register_file`. Its registered `rf_*` outputs connect directly to `we`, `waddr_rd` and `wdata_rd`.

---
 rtl/titan_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 53 +++++
 rtl/wb_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/titan_pkg.sv
// Shared core types: datapath width, register address width, writeback entry.
package titan_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    // Writeback source chosen by the arbiter in a given cycle
    typedef enum logic [1:0] {
        SrcIdle,
        SrcPipe,
        SrcFifo
    } wb_src_e;

    // Long-latency result as stored in the writeback FIFO
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO for long-latency writeback results.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    // Storage needs no reset; only valid entries are ever read out
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges in-order pipeline results with buffered
// long-latency results into the single register-file write port, tracks
// busy destination registers and throttles the pipeline to drain the FIFO.
// Optional feature macro: WB_BYPASS_EN (forward the registered write to readers).
module wb_arbiter
    import titan_pkg::*;
#(
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                p_valid,
    input  logic [REG_AW-1:0]   p_rd,
    input  logic [XLEN-1:0]     p_data,
    output logic                p_stall,
    input  logic                l_valid,
    output logic                l_ready,
    input  logic [REG_AW-1:0]   l_rd,
    input  logic [XLEN-1:0]     l_data,
    input  logic                iss_valid,
    input  logic [REG_AW-1:0]   iss_rd,
    input  logic [REG_AW-1:0]   q_rs1,
    input  logic [REG_AW-1:0]   q_rs2,
    output logic                busy_rs1,
    output logic                busy_rs2,
    output logic                fwd_rs1_hit,
    output logic                fwd_rs2_hit,
    output logic [XLEN-1:0]     fwd_rs1_data,
    output logic [XLEN-1:0]     fwd_rs2_data,
    output logic                rf_we,
    output logic [REG_AW-1:0]   rf_waddr,
    output logic [XLEN-1:0]     rf_wdata
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    wb_entry_t         head;
    wb_entry_t         push_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    wb_src_e           src;
    logic [REG_AW-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic [SW-1:0]     starve_q, starve_d;
    logic [31:0]       busy_q, busy_d;

    assign push_entry = '{rd: l_rd, data: l_data};
    assign l_ready    = !fifo_full;
    assign push       = l_valid && l_ready;
    assign p_stall    = (starve_q == SW'(STARVE_MAX)) && !fifo_empty;

    wb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .push_data (push_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head)
    );

    // Source priority: forced drain, pipeline, FIFO, idle
    always_comb begin
        src      = SrcIdle;
        sel_rd   = '0;
        sel_data = '0;
        if (p_stall) begin
            src = SrcFifo;
        end else if (p_valid) begin
            src = SrcPipe;
        end else if (!fifo_empty) begin
            src = SrcFifo;
        end
        case (src)
            SrcPipe: begin
                sel_rd   = p_rd;
                sel_data = p_data;
            end
            SrcFifo: begin
                sel_rd   = head.rd;
                sel_data = head.data;
            end
            default: ;
        endcase
    end

    assign pop = (src == SrcFifo);

    // Starvation counter and busy scoreboard next state; issue set beats pop clear
    always_comb begin
        starve_d = starve_q;
        if (pop) begin
            starve_d = '0;
        end else if (src == SrcPipe && !fifo_empty && starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end
        busy_d = busy_q;
        if (pop)       busy_d[head.rd] = 1'b0;
        if (iss_valid) busy_d[iss_rd]  = 1'b1;
        busy_d[0] = 1'b0;
    end

    // State and registered write port; address/data hold while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            busy_q   <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            starve_q <= starve_d;
            busy_q   <= busy_d;
            rf_we    <= (src != SrcIdle) && (sel_rd != '0);
            if (src != SrcIdle) begin
                rf_waddr <= sel_rd;
                rf_wdata <= sel_data;
            end
        end
    end

    assign busy_rs1 = busy_q[q_rs1];
    assign busy_rs2 = busy_q[q_rs2];

`ifdef WB_BYPASS_EN
    assign fwd_rs1_hit  = rf_we && (rf_waddr == q_rs1) && (q_rs1 != '0);
    assign fwd_rs2_hit  = rf_we && (rf_waddr == q_rs2) && (q_rs2 != '0);
    assign fwd_rs1_data = rf_wdata;
    assign fwd_rs2_data = rf_wdata;
`else
    assign fwd_rs1_hit  = 1'b0;
    assign fwd_rs2_hit  = 1'b0;
    assign fwd_rs1_data = '0;
    assign fwd_rs2_data = '0;
`endif

`ifndef SYNTHESIS
    // Reissuing to a register that still has a pending long-latency write
    a_issue_busy: assert property (@(posedge clk) disable iff (!rst_n)
        iss_valid |-> !busy_q[iss_rd])
        else $error("issue to busy rd %0d", iss_rd);

    // Pipeline must honour the stall; a write presented anyway is lost
    a_stall_ignored: assert property (@(posedge clk) disable iff (!rst_n)
        p_stall |-> !p_valid)
        else $error("pipeline write during stall dropped");
`endif

endmodule
